// File: rtl/pyfive_gpio_pkg.sv
// Shared constants for the pyfive Wishbone GPIO bank: register word indices and default width.
package pyfive_gpio_pkg;

   localparam int unsigned N_IO_DEFAULT = 16;

   // Register word indices (byte offset >> 2)
   localparam logic [5:0] REG_OUT  = 6'h00;
   localparam logic [5:0] REG_OE   = 6'h01;
   localparam logic [5:0] REG_IN   = 6'h02;
   localparam logic [5:0] REG_EDGE = 6'h03;
   localparam logic [5:0] REG_IEN  = 6'h04;
   localparam logic [5:0] REG_STAT = 6'h05;

   // Expand Wishbone byte selects into a per-bit write mask
   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/pyfive_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs.
module pyfive_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   // Shift the asynchronous input through two stages
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pyfive_wb_gpio.sv
// Wishbone-slave GPIO bank: output data/enable, synchronized inputs, edge-detect sticky IRQ.
module pyfive_wb_gpio
   import pyfive_gpio_pkg::*;
#(
   parameter int unsigned N_IO      = N_IO_DEFAULT,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic [N_IO-1:0] io_in,
   output logic [N_IO-1:0] io_out,
   output logic [N_IO-1:0] io_oeb,
   output logic            irq_o
);

   logic            ack_q;
   logic [31:0]     dat_q, dat_d;
   logic [N_IO-1:0] out_q, out_d;
   logic [N_IO-1:0] oe_q, oe_d;
   logic [N_IO-1:0] edge_q, edge_d;
   logic [N_IO-1:0] ien_q, ien_d;
   logic [N_IO-1:0] stat_q, stat_d;
   logic [N_IO-1:0] stat_clr;
   logic [N_IO-1:0] in_sync, in_prev_q;
   logic [N_IO-1:0] rise, fall, edge_hit;
   logic            irq_q;

   logic            win_hit;
   logic            req;
   logic [5:0]      reg_idx;
   logic [31:0]     bmask_full;
   logic [N_IO-1:0] bmask;
   logic [N_IO-1:0] wdat;
   logic [31:0]     rdata;
   logic            unused_bits;

   pyfive_sync2 #(
      .WIDTH (N_IO)
   ) u_sync (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_n),
      .d_i    (io_in),
      .q_o    (in_sync)
   );

   assign win_hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Blocking on ack_q gives the one-cycle ack pulse and the idle gap for a held strobe
   assign req        = wbs_cyc_i & wbs_stb_i & win_hit & ~ack_q;
   assign reg_idx    = wbs_adr_i[7:2];
   assign bmask_full = sel_to_mask(wbs_sel_i);
   assign bmask      = bmask_full[N_IO-1:0];
   assign wdat       = wbs_dat_i[N_IO-1:0];

   assign rise     = in_sync & ~in_prev_q;
   assign fall     = ~in_sync & in_prev_q;
   assign edge_hit = (rise & ~edge_q) | (fall & edge_q);

   // Address bits below the word and unused data/mask bits above N_IO
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, bmask_full};

   // Read mux: unimplemented offsets and bits above N_IO read as zero
   always_comb begin
      rdata = '0;
      case (reg_idx)
         REG_OUT:  rdata[N_IO-1:0] = out_q;
         REG_OE:   rdata[N_IO-1:0] = oe_q;
         REG_IN:   rdata[N_IO-1:0] = in_sync;
         REG_EDGE: rdata[N_IO-1:0] = edge_q;
         REG_IEN:  rdata[N_IO-1:0] = ien_q;
         REG_STAT: rdata[N_IO-1:0] = stat_q;
         default:  ;
      endcase
   end

   // Register next-state: byte-masked writes, W1C on STAT with new edges taking priority
   always_comb begin
      out_d    = out_q;
      oe_d     = oe_q;
      edge_d   = edge_q;
      ien_d    = ien_q;
      stat_clr = '0;
      if (req && wbs_we_i) begin
         case (reg_idx)
            REG_OUT:  out_d    = (out_q  & ~bmask) | (wdat & bmask);
            REG_OE:   oe_d     = (oe_q   & ~bmask) | (wdat & bmask);
            REG_EDGE: edge_d   = (edge_q & ~bmask) | (wdat & bmask);
            REG_IEN:  ien_d    = (ien_q  & ~bmask) | (wdat & bmask);
            REG_STAT: stat_clr = wdat & bmask;
            default:  ;
         endcase
      end
      stat_d = (stat_q & ~stat_clr) | edge_hit;
      dat_d  = (req && !wbs_we_i) ? rdata : '0;
   end

   // Bus handshake and software-visible registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         out_q  <= '0;
         oe_q   <= '0;
         edge_q <= '0;
         ien_q  <= '0;
         stat_q <= '0;
      end else begin
         ack_q  <= req;
         dat_q  <= dat_d;
         out_q  <= out_d;
         oe_q   <= oe_d;
         edge_q <= edge_d;
         ien_q  <= ien_d;
         stat_q <= stat_d;
      end
   end

   // Previous-sample flop for edge detect and registered interrupt level
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         in_prev_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         in_prev_q <= in_sync;
         irq_q     <= |(stat_q & ien_q);
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = out_q;
   assign io_oeb    = ~oe_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_pyfive_wb_gpio.sv
// Directed self-checking bench for pyfive_wb_gpio.
module tb_pyfive_wb_gpio;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] A_OUT  = BASE + 32'h00;
   localparam logic [31:0] A_OE   = BASE + 32'h04;
   localparam logic [31:0] A_IN   = BASE + 32'h08;
   localparam logic [31:0] A_EDGE = BASE + 32'h0C;
   localparam logic [31:0] A_IEN  = BASE + 32'h10;
   localparam logic [31:0] A_STAT = BASE + 32'h14;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, wdat = '0;
   logic        ack;
   logic [31:0] rdat;
   logic [15:0] io_in = '0;
   logic [15:0] io_out, io_oeb;
   logic        irq;

   int n_cmp = 0;
   int n_fail = 0;

   pyfive_wb_gpio #(
      .N_IO      (16),
      .BASE_ADDR (BASE)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_n  (rst_n),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oeb    (io_oeb),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_start(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
   endtask

   task automatic bus_stop();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
   endtask

   task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      bus_start(1'b1, a, d, s);
      tick();
      check({tag, "_ack"}, 32'(ack), 32'd1);
      bus_stop();
      tick();
      check({tag, "_ack_drop"}, 32'(ack), 32'd0);
   endtask

   task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus_start(1'b0, a, 32'h0, 4'hF);
      tick();
      check({tag, "_ack"}, 32'(ack), 32'd1);
      check({tag, "_data"}, rdat, exp);
      bus_stop();
      tick();
      check({tag, "_ack_drop"}, 32'(ack), 32'd0);
      check({tag, "_data_clr"}, rdat, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acks;
      int dat_nz;

      // Reset held for 3 cycles
      tick(); tick(); tick();
      check("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
      check("rst_out", 32'(io_out), 32'h0);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_dat", rdat, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      rst_n = 1'b1;
      tick();

      // Output enable and byte-lane writes
      wb_write("wr_oe", A_OE, 32'h0000_00FF, 4'hF);
      check("oeb_ff00", 32'(io_oeb), 32'h0000_FF00);
      wb_write("wr_out_b0", A_OUT, 32'h0000_A5A5, 4'b0001);
      check("out_00a5", 32'(io_out), 32'h0000_00A5);
      wb_read("rd_out", A_OUT, 32'h0000_00A5);
      wb_write("wr_out_b1", A_OUT, 32'hFFFF_FFFF, 4'b0010);
      check("out_ffa5", 32'(io_out), 32'h0000_FFA5);
      wb_read("rd_oe", A_OE, 32'h0000_00FF);
      wb_read("rd_out_lowbits", A_OUT + 32'h3, 32'h0000_FFA5);

      // Request withdrawn before any clock edge samples it
      bus_start(1'b1, A_OUT, 32'h0, 4'hF);
      #2;
      bus_stop();
      tick();
      check("cancel_ack", 32'(ack), 32'h0);
      check("cancel_out", 32'(io_out), 32'h0000_FFA5);

      // Out-of-window access: never acked, no side effect
      acks = 0;
      dat_nz = 0;
      bus_start(1'b1, BASE + 32'h100, 32'h0, 4'hF);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack) acks++;
         if (rdat != 0) dat_nz++;
      end
      bus_stop();
      check("oow_acks", 32'(acks), 32'h0);
      check("oow_dat", 32'(dat_nz), 32'h0);
      check("oow_out", 32'(io_out), 32'h0000_FFA5);
      tick();

      // Unimplemented offset and read-only IN
      wb_read("rd_3c", BASE + 32'h3C, 32'h0);
      wb_write("wr_3c", BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
      check("out_after_3c", 32'(io_out), 32'h0000_FFA5);
      check("oeb_after_3c", 32'(io_oeb), 32'h0000_FF00);
      wb_write("wr_in", A_IN, 32'hFFFF_FFFF, 4'hF);
      wb_read("rd_in_zero", A_IN, 32'h0);

      // Rising edge on pin 4 with IEN on pin 4
      wb_write("wr_edge0", A_EDGE, 32'h0, 4'hF);
      wb_write("wr_ien10", A_IEN, 32'h0000_0010, 4'hF);
      check("irq_idle", 32'(irq), 32'h0);
      io_in = 16'h0010;
      tick();
      tick();
      bus_start(1'b0, A_IN, 32'h0, 4'hF);
      tick();
      check("in_lat2_ack", 32'(ack), 32'd1);
      check("in_lat2_data", rdat, 32'h0000_0010);
      check("irq_before", 32'(irq), 32'h0);
      bus_stop();
      tick();
      check("irq_after", 32'(irq), 32'h1);
      wb_read("rd_stat10", A_STAT, 32'h0000_0010);

      // Input still shows the old value one cycle after a change
      io_in = 16'h0000;
      tick();
      bus_start(1'b0, A_IN, 32'h0, 4'hF);
      tick();
      check("in_lat1_data", rdat, 32'h0000_0010);
      bus_stop();
      tick();
      wb_read("rd_in_fell", A_IN, 32'h0);

      // W1C coinciding with a new rising edge: set wins
      io_in = 16'h0010;
      tick();
      tick();
      wb_write("w1c_race", A_STAT, 32'h0000_0010, 4'hF);
      wb_read("rd_stat_race", A_STAT, 32'h0000_0010);
      check("irq_race", 32'(irq), 32'h1);
      wb_write("w1c_plain", A_STAT, 32'h0000_0010, 4'hF);
      check("irq_cleared", 32'(irq), 32'h0);
      wb_read("rd_stat_clr", A_STAT, 32'h0);

      // Falling-edge mode on pin 0; STAT sets regardless of IEN
      wb_write("wr_edge1", A_EDGE, 32'h0000_0001, 4'hF);
      io_in = 16'h0011;
      tick(); tick(); tick(); tick();
      wb_read("rd_stat_rise_ign", A_STAT, 32'h0);
      io_in = 16'h0010;
      tick(); tick(); tick(); tick();
      wb_read("rd_stat_fall", A_STAT, 32'h0000_0001);
      check("irq_masked", 32'(irq), 32'h0);
      wb_write("wr_ien01", A_IEN, 32'h0000_0001, 4'hF);
      check("irq_unmasked", 32'(irq), 32'h1);
      wb_write("w1c_wrong_lane", A_STAT, 32'h0000_0001, 4'b0010);
      wb_read("rd_stat_kept", A_STAT, 32'h0000_0001);
      wb_write("w1c_lane0", A_STAT, 32'h0000_0001, 4'b0001);
      check("irq_w1c", 32'(irq), 32'h0);
      wb_read("rd_stat_zero", A_STAT, 32'h0);

      // Strobe held for 6 cycles: ack on alternate cycles
      acks = 0;
      bus_start(1'b0, A_OUT, 32'h0, 4'hF);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ack) acks++;
         check($sformatf("burst_ack%0d", i), 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("burst_dat%0d", i), rdat, (i % 2 == 0) ? 32'h0000_FFA5 : 32'h0);
      end
      bus_stop();
      check("burst_count", 32'(acks), 32'd3);
      tick();

      // Reset asserted mid-read
      io_in = 16'h0000;
      tick(); tick(); tick(); tick();
      bus_start(1'b0, A_OUT, 32'h0, 4'hF);
      tick();
      check("pre_rst_ack", 32'(ack), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ack", 32'(ack), 32'h0);
      check("midrst_dat", rdat, 32'h0);
      check("midrst_oeb", 32'(io_oeb), 32'h0000_FFFF);
      check("midrst_out", 32'(io_out), 32'h0);
      bus_stop();
      tick();
      rst_n = 1'b1;
      tick();
      check("postrst_irq", 32'(irq), 32'h0);
      wb_read("rd_out_rst", A_OUT, 32'h0);
      wb_read("rd_stat_rst", A_STAT, 32'h0);
      wb_read("rd_ien_rst", A_IEN, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pyfive_wb_gpio.md
Name: pyfive_wb_gpio

Overview:
Wishbone-slave GPIO bank inside pyfive_top, between the management-SoC Wishbone port and the 16 user pads io[26:11].
- Provides software-controlled output data and output enable.
- Synchronizes pad inputs.
- Detects per-pin edges into a maskable sticky interrupt status.
- Sits directly downstream of the wrapper's wbs_* and io_* connections and drives io_out/io_oeb back to it.

Parameters:
N_IO, 16, number of GPIO pins (1..32).
BASE_ADDR, 32'h3000_0000, byte base address of the 256-byte register window.

Ports:
wb_clk_i  input  1  single clock for the block.
wb_rst_n  input  1  asynchronous, active-low reset.
wbs_cyc_i  input  1  Wishbone cycle.
wbs_stb_i  input  1  Wishbone strobe.
wbs_we_i  input  1  write enable.
wbs_sel_i  input  4  byte lane select.
wbs_adr_i  input  32  byte address.
wbs_dat_i  input  32  write data.
wbs_ack_o  output  1  acknowledge.
wbs_dat_o  output  32  read data.
io_in  input  N_IO  pad inputs (asynchronous).
io_out  output  N_IO  pad output data.
io_oeb  output  N_IO  pad output enable, active-low.
irq_o  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All flops clear on wb_rst_n=0 asynchronously and release synchronously to wb_clk_i.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=all 1s (all pins input), irq_o=0.
  - All registers 0; synchronizer flops 0.
- Address decode:
  - Selected when adr[31:8]==BASE_ADDR[31:8].
  - Register index = adr[7:2]; adr[1:0] ignored.
  - Outside the window: no ack, wbs_dat_o holds 0.
- Register map (bits above N_IO read 0, writes ignored):
  - 0x00 OUT, RW: drives io_out.
  - 0x04 OE, RW: 1 = drive; io_oeb = ~OE.
  - 0x08 IN, RO: synchronized inputs. Writes are acked and ignored.
  - 0x0C EDGE, RW: per pin, 0 = rising, 1 = falling.
  - 0x10 IEN, RW: interrupt enable mask.
  - 0x14 STAT, W1C: sticky edge flags.
  - Any other offset in the window: reads 0, writes are acked and ignored.
- Handshake:
  - A request is cyc&stb&selected&!wbs_ack_o.
  - wbs_ack_o rises the cycle after the request and stays high exactly one cycle. Reads/writes take effect on that same edge; wbs_dat_o is valid while ack=1 and returns to 0 the next cycle.
  - A master holding stb across the ack gets a new ack two cycles after the previous one, so back-to-back transfers run at 50% throughput.
  - Dropping cyc or stb before the ack edge cancels the request: no ack, no register side effect.
- Byte enables: for write data bits in byte lane k, the write (or W1C) applies only when wbs_sel_i[k]=1. Reads ignore sel.
- Input path:
  - io_in goes through a 2-flop synchronizer (pyfive_sync2), then a third "previous" flop.
  - IN shows the 2nd stage; io_in-to-IN latency is 2 cycles.
  - Edge detect on cycle t: rise = s2&~s3, fall = ~s2&s3. The selected edge sets STAT[i] on the next edge, so STAT reflects an io_in change 3 cycles later.
- STAT update priority per bit: set by a new edge beats W1C clear in the same cycle. STAT bits set regardless of IEN.
- irq_o: registered |(STAT & IEN), one cycle after STAT/IEN changes.
- Reset mid-transfer: ack drops immediately; the transfer is lost; the master must retry.

Decomposition:
- Package pyfive_gpio_pkg:
  - Register offset constants REG_OUT=6'h00, REG_OE=6'h01, REG_IN=6'h02, REG_EDGE=6'h03, REG_IEN=6'h04, REG_STAT=6'h05 (word indices).
  - Default N_IO.
- Sub-module pyfive_sync2:
  - Parameter WIDTH, 2-flop synchronizer, same async active-low reset.
  - Reused later for other pad inputs.

Test Plan:
1. Reset: hold wb_rst_n=0 for 3 cycles, pulse mid-read -> io_oeb=16'hFFFF, io_out=0, ack drops the same cycle, irq_o=0.
2. Write OE=0x00FF, then OUT=0xA5A5 with sel=4'b0001 -> io_oeb=0xFF00, io_out=0x00A5; readback of OUT returns 0x000000A5 with ack exactly 1 cycle after the request.
3. io_in 0x0000->0x0010 with EDGE=0, IEN=0x0010 -> IN reads 0x0010 after 2 cycles; STAT=0x0010 after 3; irq_o=1 one cycle later.
4. W1C 0x0010 on the same cycle a new rising edge on pin 4 sets the flag -> STAT stays 0x0010. A plain W1C later -> STAT=0, irq_o=0 next cycle.
5. Access at BASE_ADDR+0x100 -> no ack for 10 cycles. Access at offset 0x3C -> ack, read 0.
6. stb held high for 6 cycles on a read -> exactly 3 acks, each 1 cycle wide, separated by 1 idle cycle.
